// File: rtl/slave.sv
// Serial bus-slave endpoint with a local 4096x8 memory.
// A frame shifts in a 14-bit address (MSB first). Write frames also shift in
// 8 data bits aligned with the last 8 address bits. Frames whose 2-bit ID
// matches SLAVE_ID either write the memory or return the addressed byte
// serially, MSB first, with a one-cycle slave_valid strobe on the first bit.
// Ports:
//   clock       - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   valid_s     - frame valid from master, high for the whole frame
//   write_en    - 1 = write frame, 0 = read frame (sampled on first frame cycle)
//   addr_rx     - serial address bit, MSB first
//   data_rx     - serial write-data bit, MSB first
//   data_tx     - serial read-data bit, MSB first (registered)
//   slave_valid - read strobe, high with the first (MSB) read bit (registered)
//   slave_ready - high while idle and able to accept a frame (registered)
module slave #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MEM_AW = 12,
  parameter logic [ADDR_W-MEM_AW-1:0] SLAVE_ID = '0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic valid_s,
  input  logic write_en,
  input  logic addr_rx,
  input  logic data_rx,
  output logic data_tx,
  output logic slave_valid,
  output logic slave_ready
);

  localparam int unsigned ID_W  = ADDR_W - MEM_AW;
  localparam int unsigned SH_W  = ADDR_W - 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TX_W  = 3;
  localparam int unsigned DEPTH = 1 << MEM_AW;

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(ADDR_W - DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(ADDR_W);
  localparam logic [TX_W-1:0]  TX_LAST    = TX_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX       = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_RD_MEM   = 3'd3;
  localparam logic [2:0] S_TX       = 3'd4;
  localparam logic [2:0] S_WAIT_LOW = 3'd5;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              armed_q;
  logic              wr_q;
  logic [SH_W-1:0]   sh_q;
  logic [ADDR_W-1:0] addr_sh;
  logic [MEM_AW-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-2:0] rd_sh;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [TX_W-1:0]   tx_cnt_q;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem [DEPTH];

  // Full address including the bit being sampled this cycle
  assign addr_sh = {sh_q, addr_rx};
  assign mem_rd  = mem[idx_q];

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid_s && armed_q) state_d = S_RX;
      end
      S_RX: begin
        if (!valid_s) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == LAST_BIT) begin
          if (addr_sh[ADDR_W-1 -: ID_W] != SLAVE_ID) state_d = S_WAIT_LOW;
          else if (wr_q)                            state_d = S_WRITE;
          else                                      state_d = S_RD_MEM;
        end
      end
      S_WRITE:  state_d = S_WAIT_LOW;
      S_RD_MEM: state_d = S_TX;
      S_TX: begin
        if (tx_cnt_q == TX_LAST) state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!valid_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_q     <= 1'b0;
      wr_q        <= 1'b0;
      sh_q        <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      rd_sh       <= '0;
      bit_cnt_q   <= '0;
      tx_cnt_q    <= '0;
      data_tx     <= 1'b0;
      slave_valid <= 1'b0;
      slave_ready <= 1'b1;
    end else begin
      // The first edge after reset release never starts a frame
      armed_q     <= 1'b1;
      slave_ready <= (state_d == S_IDLE);
      slave_valid <= 1'b0;
      data_tx     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_s && armed_q) begin
            wr_q      <= write_en;
            sh_q      <= SH_W'(addr_rx);
            bit_cnt_q <= CNT_W'(1);
            data_q    <= '0;
          end
        end
        S_RX: begin
          if (valid_s) begin
            sh_q <= addr_sh[SH_W-1:0];
            if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            // Write data rides alongside the last DATA_W address bits
            if (wr_q && (bit_cnt_q >= DATA_FIRST) && (bit_cnt_q <= LAST_BIT))
              data_q <= {data_q[DATA_W-2:0], data_rx};
            if (bit_cnt_q == LAST_BIT) idx_q <= addr_sh[MEM_AW-1:0];
          end
        end
        S_RD_MEM: begin
          // MSB goes straight out; the remaining bits queue in rd_sh
          data_tx     <= mem_rd[DATA_W-1];
          rd_sh       <= mem_rd[DATA_W-2:0];
          slave_valid <= 1'b1;
          tx_cnt_q    <= '0;
        end
        S_TX: begin
          if (tx_cnt_q != TX_LAST) begin
            data_tx  <= rd_sh[DATA_W-2];
            rd_sh    <= {rd_sh[DATA_W-3:0], 1'b0};
            tx_cnt_q <= tx_cnt_q + TX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clock) begin
    if (state_q == S_WRITE) mem[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_slave.sv
// Randomized self-checking bench for slave: a frame-level model predicts
// slave_ready / slave_valid / data_tx after every clock edge.
module tb_slave;

  logic clock;
  logic reset_n;
  logic valid_s;
  logic write_en;
  logic addr_rx;
  logic data_rx;
  logic data_tx;
  logic slave_valid;
  logic slave_ready;

  int total;
  int bad;

  logic [7:0] mem_m [4096];
  bit         wv    [4096];

  logic exp_ready;
  logic exp_valid;
  logic exp_tx;
  bit   chk_on;

  int         pulses;
  int         cap;
  logic [7:0] got_byte;

  slave dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid_s     (valid_s),
    .write_en    (write_en),
    .addr_rx     (addr_rx),
    .data_rx     (data_rx),
    .data_tx     (data_tx),
    .slave_valid (slave_valid),
    .slave_ready (slave_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, plus capture of the returned byte
  always @(negedge clock) begin
    if (chk_on) begin
      check("slave_ready", 32'(slave_ready), 32'(exp_ready));
      check("slave_valid", 32'(slave_valid), 32'(exp_valid));
      check("data_tx",     32'(data_tx),     32'(exp_tx));
      if (slave_valid === 1'b1) begin
        pulses++;
        got_byte = {7'b0, data_tx};
        cap = 1;
      end else if (cap > 0 && cap < 8) begin
        got_byte = {got_byte[6:0], data_tx};
        cap++;
      end
    end
  end

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      valid_s  = 1'b0;
      write_en = 1'($urandom);
      addr_rx  = 1'($urandom);
      data_rx  = 1'($urandom);
      @(posedge clock); #1;
      exp_ready = 1'b1; exp_valid = 1'b0; exp_tx = 1'b0;
    end
  endtask

  // One master frame; valid_s is high for vlen edges. Entered just after a
  // clock edge with the slave idle; returns once the slave is idle again.
  task automatic frame(input bit we, input logic [13:0] a, input logic [7:0] d,
                       input int vlen, input int rst_at = -1);
    bit          match;
    bit          done;
    int          i;
    int          k;
    int          busy_end;
    logic [7:0]  rd;
    logic [11:0] idx;
    idx   = a[11:0];
    match = (a[13:12] == 2'b00);
    rd    = mem_m[idx];
    // Edges after the 14th sample before the slave can see valid_s low:
    // ignored frame 1, write 2 (write cycle), read 10 (read cycle + 8 bits + 1)
    busy_end = !match ? 1 : (we ? 2 : 10);
    i    = 0;
    done = 1'b0;
    while (!done) begin
      valid_s  = (i < vlen);
      write_en = (i == 0) ? we : 1'($urandom);
      addr_rx  = (i < 14) ? a[13-i] : 1'($urandom);
      data_rx  = (i >= 6 && i < 14) ? d[13-i] : 1'($urandom);
      @(posedge clock); #1;
      exp_ready = 1'b0; exp_valid = 1'b0; exp_tx = 1'b0;
      if (vlen < 14 && i >= vlen) begin
        exp_ready = 1'b1;
        done = 1'b1;
      end else if (i >= 13) begin
        k = i - 13;
        if (match && !we) begin
          exp_valid = (k == 1);
          if (k >= 1 && k <= 8) exp_tx = rd[8-k];
        end
        if (match && we && k == 1) begin
          mem_m[idx] = d;
          wv[idx]    = 1'b1;
        end
        if (k >= busy_end && i >= vlen) begin
          exp_ready = 1'b1;
          done = 1'b1;
        end
      end
      if (i == rst_at) begin
        #1 reset_n = 1'b0;
        #1;
        check("rst_ready", 32'(slave_ready), 32'd1);
        check("rst_valid", 32'(slave_valid), 32'd0);
        check("rst_tx",    32'(data_tx),     32'd0);
        exp_ready = 1'b1; exp_valid = 1'b0; exp_tx = 1'b0;
        done = 1'b1;
      end
      i++;
    end
  endtask

  task automatic read_expect(input string name, input logic [13:0] a, input logic [7:0] val, input int vlen);
    int p0;
    p0 = pulses;
    frame(1'b0, a, 8'h00, vlen);
    check({name, "_byte"},   32'(got_byte),   32'(val));
    check({name, "_pulses"}, 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    int         pool [8];
    int         p0;
    bit         we;
    logic [1:0] id;
    logic [13:0] a;
    int         vlen;

    total = 0; bad = 0; pulses = 0; cap = 0; got_byte = '0;
    chk_on = 1'b0;
    valid_s = 1'b0; write_en = 1'b0; addr_rx = 1'b0; data_rx = 1'b0;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_tx = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_ready", 32'(slave_ready), 32'd1);
    check("reset_valid", 32'(slave_valid), 32'd0);
    check("reset_tx",    32'(data_tx),     32'd0);

    // Release reset with valid_s already high: that edge must be ignored
    @(posedge clock); #1;
    reset_n = 1'b1;
    valid_s = 1'b1;
    chk_on  = 1'b1;
    @(posedge clock); #1;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_tx = 1'b0;

    // Write A5 to address 5, valid_s held past the frame
    p0 = pulses;
    frame(1'b1, 14'h0005, 8'hA5, 16);
    check("model_mem5", 32'(mem_m[5]), 32'hA5);
    check("write_no_pulse", 32'(pulses - p0), 32'd0);
    idle(2);

    // Read back: bits 1,0,1,0,0,1,0,1
    read_expect("read5", 14'h0005, 8'hA5, 14);
    idle(1);

    // Foreign ID write must not land
    p0 = pulses;
    frame(1'b1, 14'h1005, 8'hFF, 14);
    check("foreign_no_pulse", 32'(pulses - p0), 32'd0);
    read_expect("read5_after_foreign", 14'h0005, 8'hA5, 14);

    // Aborted write after 9 bits, then normal frames
    frame(1'b1, 14'h0005, 8'h00, 9);
    read_expect("read5_after_abort", 14'h0005, 8'hA5, 14);
    frame(1'b1, 14'h0006, 8'h3C, 14);
    read_expect("read6", 14'h0006, 8'h3C, 14);

    // valid_s held for 30 cycles: a single strobe
    read_expect("read5_hold", 14'h0005, 8'hA5, 30);
    idle(1);

    // Reset while the read is shifting out
    frame(1'b0, 14'h0005, 8'h00, 14, 18);
    @(posedge clock); #1;
    reset_n = 1'b1;
    valid_s = 1'b0;
    idle(1);
    read_expect("read5_after_rst", 14'h0005, 8'hA5, 14);

    // Randomized traffic over a small address pool
    pool[0] = 5;
    for (int j = 1; j < 8; j++) pool[j] = int'($urandom_range(4095));
    for (int j = 0; j < 8; j++) frame(1'b1, {2'b00, 12'(pool[j])}, 8'($urandom), 14);
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      id = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a  = {id, 12'(pool[$urandom_range(7)])};
      if ($urandom_range(9) < 2) vlen = int'($urandom_range(1, 13));
      else if (we)               vlen = int'($urandom_range(14, 18));
      else                       vlen = int'($urandom_range(14, 30));
      frame(we, a, 8'($urandom), vlen);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
